// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//
// Purpose:
//   Captures the decoded instruction on each rising clk edge. A load in EX whose
//   destination (rtOut) feeds the ID instruction raises bubble. Bubble freezes
//   the PC and IF/ID and loads a NOP. A taken branch/jump (flush) also loads a
//   NOP. Flush suppresses bubble so the PC can take the branch target.
//   Priority: rst > flush > bubble > normal load.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   memReadIn..memToRegIn          control bits of the ID instruction
//   funcIn                         ALU function
//   readData1In, readData2In       register file reads
//   immIn                          sign-extended immediate
//   rsIn, rtIn, rdIn               register specifiers
//   flush                          branch/jump taken this cycle
//   *Out                           registered copies of the inputs above
//   stallCnt                       bubble-edge count, saturating
//                                  (only with STALL_COUNTER_EN)
//   pcWrite, ifIdWrite             PC / IF/ID enables (low while stalling)
//   bubble                         load-use hazard detected this cycle
//
// Compile option: STALL_COUNTER_EN adds the stallCnt output.

module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic        aluSrcIn,
    input  logic        regDstIn,
    input  logic        regWriteIn,
    input  logic        memToRegIn,
    input  logic [5:0]  funcIn,
    input  logic [31:0] readData1In,
    input  logic [31:0] readData2In,
    input  logic [31:0] immIn,
    input  logic [4:0]  rsIn,
    input  logic [4:0]  rtIn,
    input  logic [4:0]  rdIn,
    input  logic        flush,
    output logic        memReadOut,
    output logic        memWriteOut,
    output logic        aluSrcOut,
    output logic        regDstOut,
    output logic        regWriteOut,
    output logic        memToRegOut,
    output logic [5:0]  funcOut,
    output logic [31:0] readData1Out,
    output logic [31:0] readData2Out,
    output logic [31:0] immOut,
    output logic [4:0]  rsOut,
    output logic [4:0]  rtOut,
    output logic [4:0]  rdOut,
`ifdef STALL_COUNTER_EN
    output logic [15:0] stallCnt,
`endif
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        bubble
);

    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_alu_src;
    logic        r_reg_dst;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic [5:0]  r_func;
    logic [31:0] r_read_data1;
    logic [31:0] r_read_data2;
    logic [31:0] r_imm;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;

    logic w_rt_match;
    logic w_bubble;
    logic w_load_nop;

    // $0 is never a real destination, so a zero rt in EX cannot create a hazard.
    assign w_rt_match = (r_rt != 5'd0) && ((r_rt == rsIn) || (r_rt == rtIn));
    assign w_bubble   = r_mem_read && w_rt_match && !flush;
    assign w_load_nop = flush || w_bubble;

    always_ff @(posedge clk) begin
        if (rst || w_load_nop) begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_func       <= 6'b000000;
            r_read_data1 <= 32'd0;
            r_read_data2 <= 32'd0;
            r_imm        <= 32'd0;
            r_rs         <= 5'd0;
            r_rt         <= 5'd0;
            r_rd         <= 5'd0;
        end else begin
            r_mem_read   <= memReadIn;
            r_mem_write  <= memWriteIn;
            r_alu_src    <= aluSrcIn;
            r_reg_dst    <= regDstIn;
            r_reg_write  <= regWriteIn;
            r_mem_to_reg <= memToRegIn;
            r_func       <= funcIn;
            r_read_data1 <= readData1In;
            r_read_data2 <= readData2In;
            r_imm        <= immIn;
            r_rs         <= rsIn;
            r_rt         <= rtIn;
            r_rd         <= rdIn;
        end
    end

`ifdef STALL_COUNTER_EN
    logic [15:0] r_stall_cnt;

    // Counts only hazard NOPs; w_bubble is already masked by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (w_bubble && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stallCnt = r_stall_cnt;
`endif

    assign memReadOut   = r_mem_read;
    assign memWriteOut  = r_mem_write;
    assign aluSrcOut    = r_alu_src;
    assign regDstOut    = r_reg_dst;
    assign regWriteOut  = r_reg_write;
    assign memToRegOut  = r_mem_to_reg;
    assign funcOut      = r_func;
    assign readData1Out = r_read_data1;
    assign readData2Out = r_read_data2;
    assign immOut       = r_imm;
    assign rsOut        = r_rs;
    assign rtOut        = r_rt;
    assign rdOut        = r_rd;

    assign bubble    = w_bubble;
    assign pcWrite   = !w_bubble;
    assign ifIdWrite = !w_bubble;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReadIn, memWriteIn, aluSrcIn, regDstIn, regWriteIn, memToRegIn;
    logic [5:0]  funcIn;
    logic [31:0] readData1In, readData2In, immIn;
    logic [4:0]  rsIn, rtIn, rdIn;
    logic        flush;
    logic        memReadOut, memWriteOut, aluSrcOut, regDstOut, regWriteOut, memToRegOut;
    logic [5:0]  funcOut;
    logic [31:0] readData1Out, readData2Out, immOut;
    logic [4:0]  rsOut, rtOut, rdOut;
    logic        pcWrite, ifIdWrite, bubble;
`ifdef STALL_COUNTER_EN
    logic [15:0] stallCnt;
    logic [15:0] exp_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .memReadIn    (memReadIn),
        .memWriteIn   (memWriteIn),
        .aluSrcIn     (aluSrcIn),
        .regDstIn     (regDstIn),
        .regWriteIn   (regWriteIn),
        .memToRegIn   (memToRegIn),
        .funcIn       (funcIn),
        .readData1In  (readData1In),
        .readData2In  (readData2In),
        .immIn        (immIn),
        .rsIn         (rsIn),
        .rtIn         (rtIn),
        .rdIn         (rdIn),
        .flush        (flush),
        .memReadOut   (memReadOut),
        .memWriteOut  (memWriteOut),
        .aluSrcOut    (aluSrcOut),
        .regDstOut    (regDstOut),
        .regWriteOut  (regWriteOut),
        .memToRegOut  (memToRegOut),
        .funcOut      (funcOut),
        .readData1Out (readData1Out),
        .readData2Out (readData2Out),
        .immOut       (immOut),
        .rsOut        (rsOut),
        .rtOut        (rtOut),
        .rdOut        (rdOut),
`ifdef STALL_COUNTER_EN
        .stallCnt     (stallCnt),
`endif
        .pcWrite      (pcWrite),
        .ifIdWrite    (ifIdWrite),
        .bubble       (bubble)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        memReadIn = 0; memWriteIn = 0; aluSrcIn = 0; regDstIn = 0;
        regWriteIn = 0; memToRegIn = 0; funcIn = '0;
        readData1In = '0; readData2In = '0; immIn = '0;
        rsIn = '0; rtIn = '0; rdIn = '0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All registered outputs packed into one vector for NOP/reset checks.
    function automatic logic [31:0] fold_outs();
        return {26'd0, memReadOut, memWriteOut, aluSrcOut, regDstOut, regWriteOut, memToRegOut}
               | {26'd0, funcOut} | readData1Out | readData2Out | immOut
               | {27'd0, rsOut} | {27'd0, rtOut} | {27'd0, rdOut};
    endfunction

    // Put a load with destination rt into EX.
    task automatic load_to_ex(input logic [4:0] rt);
        clear_in();
        memReadIn = 1; regWriteIn = 1; memToRegIn = 1; aluSrcIn = 1; rtIn = rt; rsIn = 5'd1;
        tick();
    endtask

    initial begin
        // Reset with every input driven to ones.
        rst = 1; memReadIn = 1; memWriteIn = 1; aluSrcIn = 1; regDstIn = 1;
        regWriteIn = 1; memToRegIn = 1; funcIn = '1; readData1In = '1;
        readData2In = '1; immIn = '1; rsIn = '1; rtIn = '1; rdIn = '1; flush = 1;
        tick();
        chk("reset_outs", fold_outs(), 32'd0);
        chk("reset_funcOut", {26'd0, funcOut}, 32'd0);
        flush = 0;
        #1;
        chk("reset_pcWrite", {31'd0, pcWrite}, 32'd1);
        chk("reset_ifIdWrite", {31'd0, ifIdWrite}, 32'd1);
        chk("reset_bubble", {31'd0, bubble}, 32'd0);
`ifdef STALL_COUNTER_EN
        exp_cnt = 16'd0;
        chk("reset_stallCnt", {16'd0, stallCnt}, 32'd0);
`endif

        // Pass-through.
        rst = 0;
        clear_in();
        regWriteIn = 1; funcIn = 6'b100000; readData1In = 32'h5; rdIn = 5'd3;
        readData2In = 32'hDEAD_BEEF; immIn = 32'hFFFF_FFF0; aluSrcIn = 1; regDstIn = 1;
        tick();
        chk("pass_regWriteOut", {31'd0, regWriteOut}, 32'd1);
        chk("pass_funcOut", {26'd0, funcOut}, 32'h20);
        chk("pass_readData1Out", readData1Out, 32'h5);
        chk("pass_rdOut", {27'd0, rdOut}, 32'd3);
        chk("pass_readData2Out", readData2Out, 32'hDEAD_BEEF);
        chk("pass_immOut", immOut, 32'hFFFF_FFF0);
        chk("pass_ctl", {26'd0, memReadOut, memWriteOut, aluSrcOut, regDstOut, regWriteOut,
                         memToRegOut}, 32'b001110);

        // Load-use through rs.
        load_to_ex(5'd8);
        chk("lu_ex_memRead", {31'd0, memReadOut}, 32'd1);
        chk("lu_ex_rt", {27'd0, rtOut}, 32'd8);
        clear_in();
        rsIn = 5'd8; rtIn = 5'd2; rdIn = 5'd4; regWriteIn = 1; funcIn = 6'h22;
        readData1In = 32'hAA; regDstIn = 1;
        #1;
        chk("lu_bubble", {31'd0, bubble}, 32'd1);
        chk("lu_pcWrite", {31'd0, pcWrite}, 32'd0);
        chk("lu_ifIdWrite", {31'd0, ifIdWrite}, 32'd0);
        tick();
`ifdef STALL_COUNTER_EN
        exp_cnt = exp_cnt + 1;
        chk("lu_stallCnt", {16'd0, stallCnt}, {16'd0, exp_cnt});
`endif
        chk("lu_nop", fold_outs(), 32'd0);
        chk("lu_bubble_drops", {31'd0, bubble}, 32'd0);
        chk("lu_pcWrite_back", {31'd0, pcWrite}, 32'd1);
        tick();
        chk("lu_held_rs", {27'd0, rsOut}, 32'd8);
        chk("lu_held_rd", {27'd0, rdOut}, 32'd4);
        chk("lu_held_func", {26'd0, funcOut}, 32'h22);
        chk("lu_held_data1", readData1Out, 32'hAA);

        // Load-use through rt, with a non-matching case first.
        load_to_ex(5'd9);
        clear_in();
        rsIn = 5'd1; rtIn = 5'd2;
        #1;
        chk("nomatch_bubble", {31'd0, bubble}, 32'd0);
        rtIn = 5'd9;
        #1;
        chk("rt_bubble", {31'd0, bubble}, 32'd1);
        tick();
`ifdef STALL_COUNTER_EN
        exp_cnt = exp_cnt + 1;
`endif
        chk("rt_nop", fold_outs(), 32'd0);

        // Register 0 never stalls.
        load_to_ex(5'd0);
        chk("zero_ex_memRead", {31'd0, memReadOut}, 32'd1);
        clear_in();
        rsIn = 5'd0; rtIn = 5'd0; regWriteIn = 1; rdIn = 5'd7;
        #1;
        chk("zero_bubble", {31'd0, bubble}, 32'd0);
        chk("zero_pcWrite", {31'd0, pcWrite}, 32'd1);
        tick();
        chk("zero_loads_rd", {27'd0, rdOut}, 32'd7);

        // Flush overrides a live hazard.
        load_to_ex(5'd8);
        clear_in();
        rsIn = 5'd8; regWriteIn = 1; rdIn = 5'd6; flush = 1;
        #1;
        chk("fh_bubble", {31'd0, bubble}, 32'd0);
        chk("fh_pcWrite", {31'd0, pcWrite}, 32'd1);
        chk("fh_ifIdWrite", {31'd0, ifIdWrite}, 32'd1);
        tick();
        chk("fh_nop", fold_outs(), 32'd0);
`ifdef STALL_COUNTER_EN
        chk("fh_stallCnt", {16'd0, stallCnt}, {16'd0, exp_cnt});
`endif

        // Flush with no hazard still loads a NOP.
        clear_in();
        regWriteIn = 1; rdIn = 5'd5; readData2In = 32'h1234; flush = 1;
        tick();
        chk("flush_nop", fold_outs(), 32'd0);

        // Reset in the middle of a stall.
        load_to_ex(5'd8);
        clear_in();
        rsIn = 5'd8; rdIn = 5'd3; regWriteIn = 1;
        #1;
        chk("rs_stall_bubble", {31'd0, bubble}, 32'd1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("rs_outs", fold_outs(), 32'd0);
        chk("rs_bubble", {31'd0, bubble}, 32'd0);
`ifdef STALL_COUNTER_EN
        exp_cnt = 16'd0;
        chk("rs_stallCnt", {16'd0, stallCnt}, 32'd0);
`endif
        tick();
        chk("rs_id_enters", {27'd0, rsOut}, 32'd8);
        chk("rs_id_rd", {27'd0, rdOut}, 32'd3);

        // Back-to-back dependent loads: each gets its own bubble.
        load_to_ex(5'd8);
        clear_in();
        memReadIn = 1; regWriteIn = 1; rsIn = 5'd8; rtIn = 5'd10;
        #1;
        chk("b2b_bubble1", {31'd0, bubble}, 32'd1);
        tick();
`ifdef STALL_COUNTER_EN
        exp_cnt = exp_cnt + 1;
`endif
        chk("b2b_nop1", fold_outs(), 32'd0);
        tick();
        chk("b2b_load2_memRead", {31'd0, memReadOut}, 32'd1);
        chk("b2b_load2_rt", {27'd0, rtOut}, 32'd10);
        clear_in();
        rsIn = 5'd10; rtIn = 5'd3; regWriteIn = 1;
        #1;
        chk("b2b_bubble2", {31'd0, bubble}, 32'd1);
        tick();
`ifdef STALL_COUNTER_EN
        exp_cnt = exp_cnt + 1;
`endif
        chk("b2b_nop2", fold_outs(), 32'd0);
        chk("b2b_no_persist", {31'd0, bubble}, 32'd0);

`ifdef STALL_COUNTER_EN
        chk("cnt_total", {16'd0, stallCnt}, {16'd0, exp_cnt});
        // Saturation: preload near the top, then three bubble edges.
        dut.r_stall_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            load_to_ex(5'd12);
            clear_in();
            rsIn = 5'd12;
            tick();
            chk("cnt_sat", {16'd0, stallCnt}, 32'h0000_FFFF);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these decode inputs: memReadIn, memWriteIn, aluSrcIn, regDstIn, regWriteIn, memToRegIn  in  1 each  control unit outputs for the instruction in ID.
REQ-003 The block SHALL have funcIn  in  6  ALU function from control unit; readData1In, readData2In  in  32  register file reads; immIn  in  32  sign-extended immediate.
REQ-004 The block SHALL have rsIn, rtIn, rdIn  in  5  register specifiers of the ID instruction; flush  in  1  branch/jump taken (pcSrc != 00) this cycle.
REQ-005 The block SHALL have registered outputs memReadOut, memWriteOut, aluSrcOut, regDstOut, regWriteOut, memToRegOut (1 each), funcOut (6), readData1Out, readData2Out, immOut (32), rsOut, rtOut, rdOut (5).
REQ-006 The block SHALL have combinational outputs pcWrite  out  1  PC enable; ifIdWrite  out  1  IF/ID register enable; bubble  out  1  load-use hazard detected this cycle.

Function
REQ-007 Each rising clk edge with rst=0, flush=0, bubble=0, all outputs of REQ-005 SHALL load their corresponding inputs (one-cycle latency).
REQ-008 bubble SHALL equal memReadOut AND rtOut != 0 AND (rtOut == rsIn OR rtOut == rtIn) AND NOT flush.
REQ-009 pcWrite and ifIdWrite SHALL equal NOT bubble.
REQ-010 A register specifier of 0 in EX SHALL never raise bubble.
REQ-011 On an edge with bubble=1, the stage SHALL load a NOP: all six control outputs 0, funcOut 6'b000000, data and specifier outputs 0.
REQ-012 On an edge with flush=1, the stage SHALL load the same NOP as REQ-011, regardless of hazard condition.
REQ-013 Priority SHALL be rst > flush > bubble > normal load.
REQ-014 flush and hazard in the same cycle: bubble SHALL be 0, pcWrite=1, ifIdWrite=1, so the PC takes the branch target.
REQ-015 A load-use hazard SHALL stall exactly one cycle: after the NOP is loaded memReadOut=0, so bubble drops on the next cycle and the held ID instruction enters EX.
REQ-016 Back-to-back loads with dependency on each: each dependent instruction SHALL receive its own single-cycle bubble.

Reset
REQ-017 On an edge with rst=1 all REQ-005 outputs SHALL become 0 (funcOut 6'b000000); pcWrite=1, ifIdWrite=1, bubble=0 on the following cycle.
REQ-018 rst asserted mid-stall SHALL discard the stall; no stall SHALL persist after reset release.

Configuration
REQ-019 Macro STALL_COUNTER_EN SHALL be the only compile option.
REQ-020 With STALL_COUNTER_EN defined, the block SHALL add output stallCnt  out  16  count of edges on which a REQ-011 NOP was loaded due to bubble (flush NOPs excluded).
REQ-021 stallCnt SHALL reset to 0 on rst, increment by 1 per bubble edge, and saturate at 16'hFFFF.
REQ-022 Without STALL_COUNTER_EN, stallCnt SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-023 Reset: rst=1 one edge with all inputs 1s -> all outputs 0, pcWrite=1, ifIdWrite=1, bubble=0.
REQ-024 Pass-through: rst=0, regWriteIn=1, funcIn=6'b100000, readData1In=32'h5, rdIn=3 -> next edge regWriteOut=1, funcOut=6'b100000, readData1Out=32'h5, rdOut=3.
REQ-025 Load-use: EX holds memReadOut=1, rtOut=8; ID rsIn=8 -> bubble=1, pcWrite=0; next edge outputs NOP; following cycle bubble=0, ID instruction enters EX.
REQ-026 No hazard on $0: memReadOut=1, rtOut=0, rsIn=0 -> bubble=0, pcWrite=1.
REQ-027 Flush vs hazard: hazard condition as REQ-025 plus flush=1 -> bubble=0, pcWrite=1, next edge NOP, stallCnt unchanged.
REQ-028 Counter (STALL_COUNTER_EN): preload stallCnt=16'hFFFE, force 3 bubble edges -> 16'hFFFF, 16'hFFFF, 16'hFFFF.
